sample_window_buffer: RTL and testbench

- Upstream feeder for pipelined_adder in the RFID reader math path.
- Collects a serial stream of demodulated samples into a sliding window of INPUT_NUM samples.
- Presents the window as one flat concatenated word, with a one-cycle valid pulse every STRIDE accepted samples once the window is full.
- Output word is held stable between pulses so the adder tree can register it at any point in its pipeline.

---
 rtl/sample_window_buffer.sv | 100 ++++++++++
 tb/tb_sample_window_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sample_window_buffer.sv
// Sliding window of INPUT_NUM serial samples, emitted as one flat word every
// STRIDE accepted samples once the window has filled.
module sample_window_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clr)   q <= '0;
    else if (shift) q <= d;
  end
endmodule

module sample_window_buffer #(
  parameter int INPUT_NUM   = 8,
  parameter int INPUT_WIDTH = 8,
  parameter int STRIDE      = 1,
  parameter int FILL_WIDTH  = $clog2(INPUT_NUM+1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             in_vld,
  input  logic [INPUT_WIDTH-1:0]           in_dat,
  output logic                             out_vld,
  output logic [INPUT_NUM*INPUT_WIDTH-1:0] out_dat,
  output logic [FILL_WIDTH-1:0]            fill_lvl
);
  localparam int CNT_W = $clog2(STRIDE+1);
  localparam logic [FILL_WIDTH-1:0] FULL      = FILL_WIDTH'(INPUT_NUM);
  localparam logic [CNT_W-1:0]      STRIDE_M1 = CNT_W'(STRIDE-1);

  if ((STRIDE < 1) || (STRIDE > INPUT_NUM) || (INPUT_NUM < 2) ||
      ((INPUT_NUM & (INPUT_NUM-1)) != 0)) begin : g_bad_cfg
    $error("sample_window_buffer: bad INPUT_NUM/STRIDE configuration");
  end

  logic [INPUT_NUM-1:0][INPUT_WIDTH-1:0] win, win_nxt;
  logic                                  accept, emit;
  logic [CNT_W-1:0]                      cnt, cnt_nxt;

  assign accept  = in_vld & ~clr;
  // slot 0 takes the new sample; everything else moves one slot older
  assign win_nxt = {win[INPUT_NUM-2:0], in_dat};

  for (genvar k = 0; k < INPUT_NUM; k++) begin : g_slot
    sample_window_slot #(.W(INPUT_WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .shift (accept),
      .d     (win_nxt[k]),
      .q     (win[k])
    );
  end

  // First emit is the filling accept; afterwards one every STRIDE accepts.
  always_comb begin
    emit    = 1'b0;
    cnt_nxt = cnt;
    if (accept) begin
      if (fill_lvl == FULL - 1'b1) begin
        emit    = 1'b1;
        cnt_nxt = '0;
      end else if (fill_lvl == FULL) begin
        if (cnt == STRIDE_M1) begin
          emit    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      fill_lvl <= '0;
      cnt      <= '0;
    end else if (clr) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      fill_lvl <= '0;
      cnt      <= '0;
    end else begin
      out_vld <= emit;
      cnt     <= cnt_nxt;
      if (emit) out_dat <= win_nxt;
      if (accept && (fill_lvl != FULL)) fill_lvl <= fill_lvl + 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_window_buffer.sv
// Drives three strides (1, 4, 8) from one stimulus stream and checks them
// against a sample-history model plus fixed vector tables.
module tb_sample_window_buffer;
  localparam int N = 8;
  localparam int W = 8;
  localparam int STR [3] = '{1, 4, 8};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_vld = 1'b0;
  logic [W-1:0]    in_dat = '0;
  logic            o_vld  [3];
  logic [N*W-1:0]  o_dat  [3];
  logic [3:0]      o_fill [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sample_window_buffer #(.INPUT_NUM(N), .INPUT_WIDTH(W), .STRIDE(STR[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .in_vld   (in_vld),
      .in_dat   (in_dat),
      .out_vld  (o_vld[g]),
      .out_dat  (o_dat[g]),
      .fill_lvl (o_fill[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // reference: history of accepted samples since the last clear/reset
  logic [W-1:0]   hist[$];
  int             n_acc;
  logic           m_vld [3];
  logic [N*W-1:0] m_dat [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    n_acc = 0;
    for (int g = 0; g < 3; g++) begin
      m_vld[g] = 1'b0;
      m_dat[g] = '0;
    end
  endtask

  task automatic model_edge(input logic c, input logic v, input logic [W-1:0] d);
    logic [N*W-1:0] snap;
    if (c) begin
      model_reset();
      return;
    end
    for (int g = 0; g < 3; g++) m_vld[g] = 1'b0;
    if (!v) return;
    hist.push_back(d);
    if (hist.size() > N) void'(hist.pop_front());
    n_acc++;
    snap = '0;
    for (int k = 0; k < hist.size(); k++) snap[k*W +: W] = hist[hist.size()-1-k];
    for (int g = 0; g < 3; g++)
      if (n_acc >= N && ((n_acc - N) % STR[g]) == 0) begin
        m_vld[g] = 1'b1;
        m_dat[g] = snap;
      end
  endtask

  task automatic check_model();
    int f;
    f = (n_acc > N) ? N : n_acc;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("s%0d out_vld", STR[g]), 64'(o_vld[g]), 64'(m_vld[g]));
      chk($sformatf("s%0d out_dat", STR[g]), o_dat[g], m_dat[g]);
      chk($sformatf("s%0d fill_lvl", STR[g]), 64'(o_fill[g]), 64'(f));
    end
  endtask

  // inputs change at negedge; outputs checked at the following negedge
  task automatic step(input logic c, input logic v, input logic [W-1:0] d);
    clr = c; in_vld = v; in_dat = d;
    @(posedge clk);
    model_edge(c, v, d);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic         vld;
    logic [W-1:0] dat;
    logic         exp_vld;
    logic [3:0]   exp_fill;
    logic [W-1:0] exp_s0;
    logic [W-1:0] exp_s7;
  } vec_t;
  vec_t tbl [11];

  initial begin
    for (int i = 0; i < 11; i++) begin
      int s;
      s = i + 1;
      tbl[i] = '{1'b1, W'(s), (s >= N), 4'((s > N) ? N : s),
                 (s >= N) ? W'(s) : W'(0), (s >= N) ? W'(s - 7) : W'(0)};
    end

    model_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset out_vld", 64'(o_vld[g]), 64'(0));
      chk("reset out_dat", o_dat[g], 64'(0));
      chk("reset fill_lvl", 64'(o_fill[g]), 64'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    // stride 1: samples 1..11 back-to-back
    for (int i = 0; i < 11; i++) begin
      step(1'b0, tbl[i].vld, tbl[i].dat);
      chk($sformatf("tbl[%0d] vld", i), 64'(o_vld[0]), 64'(tbl[i].exp_vld));
      chk($sformatf("tbl[%0d] fill", i), 64'(o_fill[0]), 64'(tbl[i].exp_fill));
      chk($sformatf("tbl[%0d] slot0", i), 64'(o_dat[0][7:0]), 64'(tbl[i].exp_s0));
      chk($sformatf("tbl[%0d] slot7", i), 64'(o_dat[0][63:56]), 64'(tbl[i].exp_s7));
    end

    // stride 4: 1..16 with in_vld toggling; clr cycle also offers a sample
    step(1'b1, 1'b1, 8'hAA);
    for (int s = 1; s <= 16; s++) begin
      step(1'b0, 1'b1, W'(s));
      chk($sformatf("s4 pulse @%0d", s), 64'(o_vld[1]), 64'(s == 8 || s == 12 || s == 16));
      if (s == 12) begin
        chk("s4 slot0 @12", 64'(o_dat[1][7:0]), 64'(12));
        chk("s4 slot7 @12", 64'(o_dat[1][63:56]), 64'(5));
      end
      step(1'b0, 1'b0, 8'h55);
      chk("s4 gap vld", 64'(o_vld[1]), 64'(0));
    end

    // clr with in_vld after 5 samples drops that sample
    step(1'b1, 1'b0, 8'h00);
    for (int s = 1; s <= 5; s++) step(1'b0, 1'b1, W'(8'h30 + s));
    step(1'b1, 1'b1, 8'hEE);
    chk("clr fill", 64'(o_fill[0]), 64'(0));
    chk("clr dat", o_dat[0], 64'(0));
    for (int s = 1; s <= 8; s++) begin
      step(1'b0, 1'b1, W'(8'h40 + s));
      chk($sformatf("post-clr pulse @%0d", s), 64'(o_vld[0]), 64'(s == 8));
    end
    chk("post-clr slot7", 64'(o_dat[0][63:56]), 64'(8'h41));

    // asynchronous reset mid-cycle after 6 samples
    step(1'b1, 1'b0, 8'h00);
    for (int s = 1; s <= 6; s++) step(1'b0, 1'b1, W'(8'h60 + s));
    in_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("async rst vld", 64'(o_vld[g]), 64'(0));
      chk("async rst dat", o_dat[g], 64'(0));
      chk("async rst fill", 64'(o_fill[g]), 64'(0));
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step(1'b0, 1'b1, W'(8'h70 + s));
      chk($sformatf("post-rst pulse @%0d", s), 64'(o_vld[0]), 64'(s == 8));
    end

    // stride 8: all-ones window then all-zeros window
    step(1'b1, 1'b0, 8'h00);
    for (int s = 1; s <= 16; s++) begin
      step(1'b0, 1'b1, (s <= 8) ? 8'hFF : 8'h00);
      chk($sformatf("s8 pulse @%0d", s), 64'(o_vld[2]), 64'(s == 8 || s == 16));
      if (s == 8)  chk("s8 dat ones", o_dat[2], {N*W{1'b1}});
      if (s == 16) chk("s8 dat zeros", o_dat[2], 64'(0));
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
